// File: rtl/vproc_hazard_scoreboard.sv
// rtl/vproc_hazard_scoreboard.sv - per-register in-flight write counters gating vector issue
module vproc_hazard_scoreboard #(
    parameter int unsigned VREG_CNT       = 32,
    parameter int unsigned CNT_W          = 2,
    parameter int unsigned RETIRE_CH      = 2,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          async_rst_ni,
    input  logic                          flush_i,
    input  logic                          issue_valid_i,
    output logic                          issue_ready_o,
    input  logic [VREG_CNT-1:0]           issue_wr_mask_i,
    input  logic [VREG_CNT-1:0]           issue_rd_mask_i,
    input  logic [RETIRE_CH-1:0]          retire_valid_i,
    input  logic [RETIRE_CH*VREG_CNT-1:0] retire_mask_i,
    output logic [VREG_CNT-1:0]           pending_wr_o,
    output logic                          idle_o,
    output logic                          err_o
);

    // Two extra bits leave headroom for count + one issue - all retires.
    localparam int unsigned AW = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [AW-1:0]    CNT_MAX_W = {2'b00, CNT_MAX};

    logic [CNT_W-1:0]    cnt_q [VREG_CNT];
    logic [CNT_W-1:0]    cnt_d [VREG_CNT];
    logic                err_q;
    logic                err_d;
    logic [VREG_CNT-1:0] ch_mask [RETIRE_CH];
    logic                raw_hit;
    logic                sat_hit;
    logic                issue_fire;
    logic [AW-1:0]       sum;
    logic [AW-1:0]       dec;
    logic [AW-1:0]       diff;

    // Pending/idle status and the issue gate, all from registered counters.
    always_comb begin
        pending_wr_o = '0;
        sat_hit      = 1'b0;
        for (int r = 0; r < VREG_CNT; r++) begin
            pending_wr_o[r] = (cnt_q[r] != '0);
            if (issue_wr_mask_i[r] && (cnt_q[r] == CNT_MAX)) begin
                sat_hit = 1'b1;
            end
        end
        raw_hit       = |(issue_rd_mask_i & pending_wr_o);
        issue_ready_o = ~raw_hit & ~sat_hit;
        issue_fire    = issue_valid_i & issue_ready_o;
        idle_o        = ~|pending_wr_o;
        err_o         = err_q;
    end

    // Net counter update: +1 for an accepted write, -1 per retiring channel, clamped.
    always_comb begin
        err_d = err_q;
        sum   = '0;
        dec   = '0;
        diff  = '0;
        for (int c = 0; c < RETIRE_CH; c++) begin
            if (retire_valid_i[c]) begin
                ch_mask[c] = retire_mask_i[c*VREG_CNT +: VREG_CNT];
            end else begin
                ch_mask[c] = DONT_CARE_ZERO ? '0 : 'x;
            end
        end
        for (int r = 0; r < VREG_CNT; r++) begin
            sum = AW'(cnt_q[r]) + AW'(issue_fire & issue_wr_mask_i[r]);
            dec = '0;
            for (int c = 0; c < RETIRE_CH; c++) begin
                dec = dec + AW'(retire_valid_i[c] & ch_mask[c][r]);
            end
            if (dec > sum) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else begin
                diff = sum - dec;
                if (diff > CNT_MAX_W) begin
                    cnt_d[r] = CNT_MAX;
                    err_d    = 1'b1;
                end else begin
                    cnt_d[r] = diff[CNT_W-1:0];
                end
            end
        end
        if (flush_i) begin
            for (int r = 0; r < VREG_CNT; r++) begin
                cnt_d[r] = '0;
            end
            err_d = 1'b0;
        end
    end

    // Counter and sticky error state; reset drops all in-flight tracking.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            for (int r = 0; r < VREG_CNT; r++) begin
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < VREG_CNT; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_vproc_hazard_scoreboard.sv
// tb/tb_vproc_hazard_scoreboard.sv - scoreboard bench for vproc_hazard_scoreboard
module tb_vproc_hazard_scoreboard;

    localparam int unsigned VREG_CNT  = 32;
    localparam int unsigned RETIRE_CH = 2;

    logic                          clk_i = 1'b0;
    logic                          async_rst_ni;
    logic                          flush_i;
    logic                          issue_valid_i;
    logic                          issue_ready_o;
    logic [VREG_CNT-1:0]           issue_wr_mask_i;
    logic [VREG_CNT-1:0]           issue_rd_mask_i;
    logic [RETIRE_CH-1:0]          retire_valid_i;
    logic [RETIRE_CH*VREG_CNT-1:0] retire_mask_i;
    logic [VREG_CNT-1:0]           pending_wr_o;
    logic                          idle_o;
    logic                          err_o;

    typedef struct {
        int          id;
        logic [31:0] pend;
        logic        idle;
        logic        rdy;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   chk_id  = 0;

    vproc_hazard_scoreboard #(
        .VREG_CNT(VREG_CNT), .CNT_W(2), .RETIRE_CH(RETIRE_CH), .DONT_CARE_ZERO(1'b1)
    ) dut (
        .clk_i(clk_i), .async_rst_ni(async_rst_ni), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_wr_mask_i(issue_wr_mask_i), .issue_rd_mask_i(issue_rd_mask_i),
        .retire_valid_i(retire_valid_i), .retire_mask_i(retire_mask_i),
        .pending_wr_o(pending_wr_o), .idle_o(idle_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    // Monitor: every falling edge, check all expectations queued for this cycle.
    always @(negedge clk_i) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (pending_wr_o !== e.pend) begin
                n_fail++;
                $display("FAIL chk%0d pending_wr: got %h required %h", e.id, pending_wr_o, e.pend);
            end
            n_tests++;
            if (idle_o !== e.idle) begin
                n_fail++;
                $display("FAIL chk%0d idle: got %b required %b", e.id, idle_o, e.idle);
            end
            n_tests++;
            if (issue_ready_o !== e.rdy) begin
                n_fail++;
                $display("FAIL chk%0d issue_ready: got %b required %b", e.id, issue_ready_o, e.rdy);
            end
            n_tests++;
            if (err_o !== e.err) begin
                n_fail++;
                $display("FAIL chk%0d err: got %b required %b", e.id, err_o, e.err);
            end
        end
    end

    task automatic expect_now(input logic [31:0] pend, input logic idle,
                              input logic rdy, input logic err);
        exp_t e;
        chk_id++;
        e.id = chk_id; e.pend = pend; e.idle = idle; e.rdy = rdy; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] wr, input logic [31:0] rd,
                         input logic [1:0] rv, input logic [31:0] m0, input logic [31:0] m1);
        issue_valid_i   = v;
        issue_wr_mask_i = wr;
        issue_rd_mask_i = rd;
        retire_valid_i  = rv;
        retire_mask_i   = {m1, m0};
    endtask

    initial begin
        async_rst_ni = 1'b0;
        flush_i      = 1'b0;
        drive(0, 0, 0, 2'b00, 0, 0);
        step(); step();
        async_rst_ni = 1'b1;
        expect_now(32'h0, 1, 1, 0);

        // RAW on v4 after issuing v4,v5; retire clears it one cycle later
        step();
        drive(1, 32'h30, 0, 2'b00, 0, 0);          expect_now(32'h0, 1, 1, 0);
        step();
        drive(0, 0, 32'h10, 2'b01, 32'h30, 0);     expect_now(32'h30, 0, 0, 0);
        step();
        drive(0, 0, 32'h10, 2'b00, 0, 0);          expect_now(32'h0, 1, 1, 0);

        // WAW up to saturation on v0
        step();
        drive(1, 32'h1, 0, 2'b00, 0, 0);           expect_now(32'h0, 1, 1, 0);
        step();                                    expect_now(32'h1, 0, 1, 0);
        step();                                    expect_now(32'h1, 0, 1, 0);
        step();                                    expect_now(32'h1, 0, 0, 0);
        step();
        drive(0, 32'h1, 0, 2'b10, 0, 32'h1);       expect_now(32'h1, 0, 0, 0);
        step();
        drive(0, 32'h1, 0, 2'b00, 0, 0);           expect_now(32'h1, 0, 1, 0);
        step();
        drive(0, 0, 0, 2'b11, 32'h1, 32'h1);       expect_now(32'h1, 0, 1, 0);
        step();
        drive(0, 0, 0, 2'b00, 0, 0);               expect_now(32'h0, 1, 1, 0);

        // Simultaneous issue and double retire on v8, then an over-retire
        step();
        drive(1, 32'h100, 0, 2'b00, 0, 0);         expect_now(32'h0, 1, 1, 0);
        step();
        drive(1, 32'h100, 0, 2'b11, 32'h100, 32'h100); expect_now(32'h100, 0, 1, 0);
        step();
        drive(1, 32'h100, 0, 2'b00, 0, 0);         expect_now(32'h0, 1, 1, 0);
        step();
        drive(0, 0, 0, 2'b11, 32'h100, 32'h100);   expect_now(32'h100, 0, 1, 0);
        step();
        drive(0, 0, 0, 2'b00, 0, 0);               expect_now(32'h0, 1, 1, 1);

        // Flush beats an accepted issue and clears the error
        step();
        drive(1, 32'h2, 0, 2'b00, 0, 0);           expect_now(32'h0, 1, 1, 1);
        step();
        flush_i = 1'b1;
        drive(1, 32'h4, 0, 2'b01, 32'h2, 0);       expect_now(32'h2, 0, 1, 1);
        step();
        flush_i = 1'b0;
        drive(0, 0, 0, 2'b00, 0, 0);               expect_now(32'h0, 1, 1, 0);

        // Asynchronous reset between edges, then a stray retire
        step();
        drive(1, 32'hE, 0, 2'b00, 0, 0);           expect_now(32'h0, 1, 1, 0);
        step();
        drive(0, 0, 32'h2, 2'b00, 0, 0);           expect_now(32'hE, 0, 0, 0);
        step();
        #1;
        async_rst_ni = 1'b0;
        expect_now(32'h0, 1, 1, 0);
        step();
        async_rst_ni = 1'b1;
        drive(0, 0, 0, 2'b01, 32'h2, 0);           expect_now(32'h0, 1, 1, 0);
        step();
        drive(0, 0, 0, 2'b00, 0, 0);               expect_now(32'h0, 1, 1, 1);

        repeat (2) @(negedge clk_i);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
